// File: rtl/ysyx_22050078_hazard_scoreboard_pkg.sv
// Shared widths and stage indices for the forwarding / hazard unit.
package ysyx_22050078_hazard_scoreboard_pkg;

    localparam int unsigned CPU_WIDTH  = 64;
    localparam int unsigned REG_ADDRW  = 5;
    localparam int unsigned NREAD_DEF  = 2;
    localparam int unsigned NSTAGE_DEF = 3;
    localparam int unsigned STAGE_EX   = 0;

endpackage

// File: rtl/ysyx_22050078_fwd_mux.sv
// Priority operand select for one source port: x0, in-flight stages (youngest first),
// long-latency write-back, then regfile.
module ysyx_22050078_fwd_mux
    import ysyx_22050078_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = CPU_WIDTH,
    parameter int unsigned REGW   = REG_ADDRW,
    parameter int unsigned NSTAGE = NSTAGE_DEF
) (
    input  logic [REGW-1:0]        rs_addr,
    input  logic [NSTAGE-1:0]      fwd_wen,
    input  logic [NSTAGE-1:0]      fwd_rdy,
    input  logic [NSTAGE*REGW-1:0] fwd_rd_addr,
    input  logic [NSTAGE*XLEN-1:0] fwd_data,
    input  logic                   lc_wen,
    input  logic [REGW-1:0]        lc_rd_addr,
    input  logic [XLEN-1:0]        lc_data,
    input  logic [XLEN-1:0]        reg_rdata,
    output logic [XLEN-1:0]        data,
    output logic                   hit,
    output logic                   notready
);

    logic found;

    always_comb begin
        data     = reg_rdata;
        hit      = 1'b0;
        notready = 1'b0;
        found    = 1'b0;
        if (rs_addr == '0) begin
            data  = '0;
            found = 1'b1;
        end
        for (int s = 0; s < NSTAGE; s++) begin
            if (!found && fwd_wen[s] && fwd_rd_addr[s*REGW +: REGW] == rs_addr) begin
                found    = 1'b1;
                hit      = 1'b1;
                notready = !fwd_rdy[s];
                // A not-ready hit still blocks older sources; the stall covers the stale value.
                if (fwd_rdy[s]) begin
                    data = fwd_data[s*XLEN +: XLEN];
                end
            end
        end
        if (!found && lc_wen && lc_rd_addr == rs_addr) begin
            hit  = 1'b1;
            data = lc_data;
        end
    end

endmodule

// File: rtl/ysyx_22050078_hazard_scoreboard.sv
// Operand forwarding, long-latency scoreboard, stall generation and the registered
// load->store data bypass.
module ysyx_22050078_hazard_scoreboard
    import ysyx_22050078_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = CPU_WIDTH,
    parameter int unsigned REGW   = REG_ADDRW,
    parameter int unsigned NREAD  = NREAD_DEF,
    parameter int unsigned NSTAGE = NSTAGE_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREAD*REGW-1:0]  i_id_rs_addr,
    input  logic [NREAD-1:0]       i_id_rs_used,
    input  logic                   i_id_sten,
    input  logic                   i_id_lcen,
    input  logic [REGW-1:0]        i_id_rd_addr,
    input  logic                   i_id_fire,
    input  logic                   i_flush,
    input  logic [NSTAGE-1:0]      i_fwd_wen,
    input  logic [NSTAGE-1:0]      i_fwd_rdy,
    input  logic [NSTAGE*REGW-1:0] i_fwd_rd_addr,
    input  logic [NSTAGE*XLEN-1:0] i_fwd_data,
    input  logic                   i_lc_wen,
    input  logic [REGW-1:0]        i_lc_rd_addr,
    input  logic [XLEN-1:0]        i_lc_data,
    input  logic [NREAD*XLEN-1:0]  i_reg_rdata,
    input  logic [XLEN-1:0]        i_ex_rs2,
    input  logic [XLEN-1:0]        i_ls_lsres,
    output logic [NREAD*XLEN-1:0]  o_rs_data,
    output logic                   o_stall,
    output logic [XLEN-1:0]        o_st_data,
    output logic [REGW:0]          o_sb_cnt
);

    localparam int unsigned NREG = 2 ** REGW;
    localparam int unsigned STP  = NREAD - 1;

    logic [NREG-1:0]  pend_q, pend_d;
    logic [REGW:0]    cnt_q, cnt_d;
    logic             ldst_q;
    logic [NREAD-1:0] fwd_hit, fwd_nr, ex_first;
    logic [REGW-1:0]  rd_ex;
    logic             load_use, sb_hit, waw, ldst_bp;
    logic             sb_set, sb_clr, same_addr, cnt_inc, cnt_dec;

    assign rd_ex = i_fwd_rd_addr[STAGE_EX*REGW +: REGW];

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        ysyx_22050078_fwd_mux #(
            .XLEN  (XLEN),
            .REGW  (REGW),
            .NSTAGE(NSTAGE)
        ) u_fwd_mux (
            .rs_addr    (i_id_rs_addr[k*REGW +: REGW]),
            .fwd_wen    (i_fwd_wen),
            .fwd_rdy    (i_fwd_rdy),
            .fwd_rd_addr(i_fwd_rd_addr),
            .fwd_data   (i_fwd_data),
            .lc_wen     (i_lc_wen),
            .lc_rd_addr (i_lc_rd_addr),
            .lc_data    (i_lc_data),
            .reg_rdata  (i_reg_rdata[k*XLEN +: XLEN]),
            .data       (o_rs_data[k*XLEN +: XLEN]),
            .hit        (fwd_hit[k]),
            .notready   (fwd_nr[k])
        );
        // EX has top priority, so any EX match is the first hit.
        assign ex_first[k] = i_fwd_wen[STAGE_EX] && rd_ex == i_id_rs_addr[k*REGW +: REGW]
                             && rd_ex != '0;
    end

    always_comb begin
        load_use = 1'b0;
        sb_hit   = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            if (i_id_rs_used[k] && fwd_nr[k]
                && !(k == STP && i_id_sten && ex_first[k])) begin
                load_use = 1'b1;
            end
            if (i_id_rs_used[k] && pend_q[i_id_rs_addr[k*REGW +: REGW]] && !fwd_hit[k]) begin
                sb_hit = 1'b1;
            end
        end
    end

    assign waw     = i_id_lcen && pend_q[i_id_rd_addr]
                     && !(i_lc_wen && i_lc_rd_addr == i_id_rd_addr);
    assign o_stall = load_use | sb_hit | waw;
    assign ldst_bp = i_id_sten && i_fwd_wen[STAGE_EX] && !i_fwd_rdy[STAGE_EX] && ex_first[STP];

    assign sb_set    = i_id_fire && i_id_lcen && !i_flush && i_id_rd_addr != '0;
    assign sb_clr    = i_lc_wen && i_lc_rd_addr != '0;
    assign same_addr = sb_set && sb_clr && i_id_rd_addr == i_lc_rd_addr;
    // Only clears of pending entries count, so the counter cannot underflow.
    assign cnt_inc   = sb_set && !pend_q[i_id_rd_addr] && !same_addr;
    assign cnt_dec   = sb_clr && pend_q[i_lc_rd_addr] && !same_addr;

    always_comb begin
        pend_d = pend_q;
        if (sb_clr) begin
            pend_d[i_lc_rd_addr] = 1'b0;
        end
        if (sb_set) begin
            pend_d[i_id_rd_addr] = 1'b1;
        end
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
            ldst_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            ldst_q <= ldst_bp && i_id_fire && !i_flush;
        end
    end

    assign o_st_data = ldst_q ? i_ls_lsres : i_ex_rs2;
    assign o_sb_cnt  = cnt_q;

endmodule

// File: tb/tb_ysyx_22050078_hazard_scoreboard.sv
// Directed bench: table of combinational forwarding/stall vectors plus scoreboard,
// bypass and reset sequences.
module tb_ysyx_22050078_hazard_scoreboard;

    localparam logic [63:0] D0 = 64'h11, D1 = 64'h33, D2 = 64'h22;
    localparam logic [63:0] RA = 64'hA0, RB = 64'hB0, LC = 64'h99;
    localparam logic [63:0] EXS = 64'hE5E5, LSR = 64'h5A5A;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [9:0]   rs_addr;
    logic [1:0]   rs_used;
    logic         sten, lcen, fire, flush, lc_wen;
    logic [4:0]   rd_addr, lc_rd;
    logic [2:0]   fwd_wen, fwd_rdy;
    logic [14:0]  fwd_rd;
    logic [191:0] fwd_data;
    logic [63:0]  lc_data;
    logic [127:0] reg_rdata, rs_data;
    logic         stall;
    logic [63:0]  st_data;
    logic [5:0]   sb_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050078_hazard_scoreboard dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_id_rs_addr (rs_addr),
        .i_id_rs_used (rs_used),
        .i_id_sten    (sten),
        .i_id_lcen    (lcen),
        .i_id_rd_addr (rd_addr),
        .i_id_fire    (fire),
        .i_flush      (flush),
        .i_fwd_wen    (fwd_wen),
        .i_fwd_rdy    (fwd_rdy),
        .i_fwd_rd_addr(fwd_rd),
        .i_fwd_data   (fwd_data),
        .i_lc_wen     (lc_wen),
        .i_lc_rd_addr (lc_rd),
        .i_lc_data    (lc_data),
        .i_reg_rdata  (reg_rdata),
        .i_ex_rs2     (EXS),
        .i_ls_lsres   (LSR),
        .o_rs_data    (rs_data),
        .o_stall      (stall),
        .o_st_data    (st_data),
        .o_sb_cnt     (sb_cnt)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [1:0]  used;
        logic        sten;
        logic [2:0]  wen, rdy;
        logic [4:0]  rd0, rd1, rd2;
        logic        lcw;
        logic [4:0]  lcrd;
        logic        chk0, chk1;
        logic [63:0] exp0, exp1;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_addr = '0; rs_used = '0; sten = 0; lcen = 0; rd_addr = '0; fire = 0; flush = 0;
        fwd_wen = '0; fwd_rdy = '1; fwd_rd = '0; lc_wen = 0; lc_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        rs_addr = {v.rs2, v.rs1}; rs_used = v.used; sten = v.sten;
        fwd_wen = v.wen; fwd_rdy = v.rdy; fwd_rd = {v.rd2, v.rd1, v.rd0};
        lc_wen = v.lcw; lc_rd = v.lcrd;
    endtask

    initial begin
        fwd_data  = {D2, D1, D0};
        reg_rdata = {RB, RA};
        lc_data   = LC;
        idle();
        //          rs1 rs2  used  st wen     rdy     rd0 rd1 rd2 lcw lcrd c0 c1 exp0 exp1 stall
        vecs[0]  = '{5, 0, 2'b01, 0, 3'b101, 3'b111, 5, 0, 5, 0, 0, 1, 1, D0, 0,  0};
        vecs[1]  = '{0, 0, 2'b11, 0, 3'b111, 3'b111, 0, 0, 0, 0, 0, 1, 1, 0,  0,  0};
        vecs[2]  = '{5, 4, 2'b11, 0, 3'b100, 3'b111, 0, 0, 5, 0, 0, 1, 1, D2, RB, 0};
        vecs[3]  = '{3, 4, 2'b11, 0, 3'b000, 3'b111, 0, 0, 0, 0, 0, 1, 1, RA, RB, 0};
        vecs[4]  = '{3, 4, 2'b11, 0, 3'b000, 3'b111, 0, 0, 0, 1, 3, 1, 1, LC, RB, 0};
        vecs[5]  = '{3, 4, 2'b11, 0, 3'b010, 3'b111, 0, 3, 0, 1, 3, 1, 1, D1, RB, 0};
        vecs[6]  = '{7, 0, 2'b01, 0, 3'b001, 3'b110, 7, 0, 0, 0, 0, 0, 1, 0,  0,  1};
        vecs[7]  = '{3, 7, 2'b11, 1, 3'b001, 3'b110, 7, 0, 0, 0, 0, 1, 0, RA, 0,  0};
        vecs[8]  = '{3, 7, 2'b11, 1, 3'b010, 3'b101, 0, 7, 0, 0, 0, 1, 0, RA, 0,  1};
        vecs[9]  = '{7, 0, 2'b00, 0, 3'b001, 3'b110, 7, 0, 0, 0, 0, 0, 1, 0,  0,  0};
        vecs[10] = '{7, 0, 2'b01, 0, 3'b011, 3'b101, 7, 7, 0, 0, 0, 1, 1, D0, 0,  0};
        vecs[11] = '{0, 0, 2'b01, 0, 3'b001, 3'b110, 0, 0, 0, 0, 0, 1, 1, 0,  0,  0};

        tick(); tick();
        check("reset_cnt", 64'(sb_cnt), 0);
        check("reset_st_data", st_data, EXS);
        check("reset_stall", 64'(stall), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            if (vecs[i].chk0) check($sformatf("vec%0d_op0", i), rs_data[63:0], vecs[i].exp0);
            if (vecs[i].chk1) check($sformatf("vec%0d_op1", i), rs_data[127:64], vecs[i].exp1);
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
            tick();
        end
        idle();
        tick();

        // Load->store bypass: store fires past a not-ready EX load
        apply(vecs[7]); fire = 1;
        tick(); idle();
        check("ldst_bypass", st_data, LSR);
        tick();
        check("ldst_clear", st_data, EXS);

        // Scoreboard RAW resolved by same-cycle write-back
        lcen = 1; rd_addr = 9; fire = 1;
        tick(); idle();
        check("sb_set_cnt", 64'(sb_cnt), 1);
        rs_addr = 10'd9; rs_used = 2'b01;
        #1 check("sb_raw_stall", 64'(stall), 1);
        tick();
        check("sb_raw_stall_hold", 64'(stall), 1);
        lc_wen = 1; lc_rd = 9;
        #1 check("sb_wb_stall", 64'(stall), 0);
        check("sb_wb_operand", rs_data[63:0], LC);
        fire = 1;
        tick(); idle();
        check("sb_wb_cnt", 64'(sb_cnt), 0);

        // WAW and simultaneous set/clear
        lcen = 1; rd_addr = 4; fire = 1;
        tick(); idle();
        check("waw_cnt1", 64'(sb_cnt), 1);
        lcen = 1; rd_addr = 4;
        #1 check("waw_stall", 64'(stall), 1);
        lc_wen = 1; lc_rd = 4;
        #1 check("waw_wb_stall", 64'(stall), 0);
        fire = 1;
        tick(); idle();
        check("waw_same_cnt", 64'(sb_cnt), 1);
        rs_addr = 10'd4; rs_used = 2'b01;
        #1 check("waw_still_pend", 64'(stall), 1);
        idle();

        // Flushed long op does not pend
        lcen = 1; rd_addr = 6; fire = 1; flush = 1;
        tick(); idle();
        check("flush_cnt", 64'(sb_cnt), 1);
        rs_addr = 10'd6; rs_used = 2'b01;
        #1 check("flush_no_pend", 64'(stall), 0);
        idle(); lc_wen = 1; lc_rd = 4;
        tick(); idle();
        check("clear4_cnt", 64'(sb_cnt), 0);

        // x0 never pends; clear of unpended address is ignored
        lcen = 1; rd_addr = 0; fire = 1;
        tick(); idle();
        check("rd0_cnt", 64'(sb_cnt), 0);
        lc_wen = 1; lc_rd = 12;
        tick(); idle();
        check("no_underflow", 64'(sb_cnt), 0);

        // Asynchronous reset mid-stream
        lcen = 1; rd_addr = 10; fire = 1;
        tick(); idle();
        apply(vecs[7]); fire = 1;
        tick(); idle();
        check("pre_reset_cnt", 64'(sb_cnt), 1);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_cnt", 64'(sb_cnt), 0);
        check("mid_reset_st", st_data, EXS);
        check("mid_reset_stall", 64'(stall), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        lc_wen = 1; lc_rd = 10;
        tick(); idle();
        check("late_wb_cnt", 64'(sb_cnt), 0);
        rs_addr = 10'd10; rs_used = 2'b01;
        #1 check("post_reset_stall", 64'(stall), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
